// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : regfile_pkg                                                     |
// | Purpose  : Shared constants, address-width helper and write-request type   |
// |            for the multi-port register file and its busy scoreboard.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;

  // Never returns 0 so a single-register file still gets a 1-bit address.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DEFAULT_ADDR_W = addr_width(DEFAULT_DEPTH);

  // One write port's request at the default geometry.
  typedef struct packed {
    logic                      en;
    logic [DEFAULT_ADDR_W-1:0] addr;
    logic [DEFAULT_WIDTH-1:0]  data;
  } wr_req_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_scoreboard                                              |
// | Purpose  : Per-register busy bits. A reservation is accepted when the     |
// |            target is in range and idle; an accepted reservation sets the   |
// |            bit, a writeback to the register clears it, set beats clear.    |
// | Ports    : clock, reset (async, active-low)                                |
// |            rsv_en/rsv_addr in  - reservation request                       |
// |            clear[DEPTH]   in  - registers written on this edge            |
// |            busy[DEPTH]    out - current busy bits                          |
// |            rsv_ok         out - reservation accepted this cycle           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = addr_width(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [DEPTH-1:0]  clear,
  output logic [DEPTH-1:0]  busy,
  output logic              rsv_ok
);

  logic rsv_in_range;

  assign rsv_in_range = (32'(rsv_addr) < 32'(DEPTH));
  // Gated by reset so nothing is accepted while the block is held in reset.
  assign rsv_ok = reset && rsv_en && rsv_in_range && !busy[rsv_addr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        if (ZERO_REG != 0 && a == 0) begin
          busy[a] <= 1'b0;  // hardwired zero register is never pending
        end else if (rsv_ok && rsv_addr == ADDR_W'(a)) begin
          busy[a] <= 1'b1;  // new producer supersedes a same-edge writeback
        end else if (clear[a]) begin
          busy[a] <= 1'b0;
        end
      end
    end
  end

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_mp                                                      |
// | Purpose  : Parametrised register file, NRD combinational read ports, NWR   |
// |            write ports (highest index wins on collision), optional         |
// |            hardwired-zero register 0 and a busy scoreboard.               |
// | Macro    : REGFILE_BYPASS_EN - same-cycle write-to-read forwarding.        |
// | Ports    : clock, reset (async, active-low)                                |
// |            rd_addr/rd_data/rd_busy - packed read ports                     |
// |            wr_en/wr_addr/wr_data   - packed write ports                    |
// |            rsv_en/rsv_addr/rsv_ok  - busy reservation                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = addr_width(DEPTH),
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*WIDTH-1:0]  rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*WIDTH-1:0]  wr_data,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic                  rsv_ok
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] we;           // register written on the coming edge
  logic [WIDTH-1:0] wd [DEPTH];   // winning data for that register
  logic [DEPTH-1:0] busy;

  // Per-register write decode. Later (higher-index) ports overwrite earlier
  // ones, which gives the collision priority. Out-of-range addresses match no
  // register; register 0 is excluded when hardwired to zero.
  always_comb begin
    for (int a = 0; a < DEPTH; a++) begin
      we[a] = 1'b0;
      wd[a] = '0;
      for (int i = 0; i < NWR; i++) begin
        if (reset && wr_en[i] && wr_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(a)
            && !(ZERO_REG != 0 && a == 0)) begin
          we[a] = 1'b1;
          wd[a] = wr_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        if (we[a]) mem[a] <= wd[a];
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .clear    (we),
    .busy     (busy),
    .rsv_ok   (rsv_ok)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              in_range;

    assign addr     = rd_addr[k*ADDR_W +: ADDR_W];
    assign in_range = (32'(addr) < 32'(DEPTH));

`ifdef REGFILE_BYPASS_EN
    // A pending write shows through immediately; its busy bit reads as
    // cleared unless a reservation of the same register is accepted now.
    assign rd_data[k*WIDTH +: WIDTH] = !in_range ? '0 :
                                       we[addr]  ? wd[addr] : mem[addr];
    assign rd_busy[k] = !in_range ? 1'b0 :
                        we[addr]  ? (rsv_ok && rsv_addr == addr) : busy[addr];
`else
    assign rd_data[k*WIDTH +: WIDTH] = in_range ? mem[addr] : '0;
    assign rd_busy[k]                = in_range ? busy[addr] : 1'b0;
`endif
  end : g_rd

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_regfile_mp                                                   |
// | Purpose  : Directed self-checking bench for regfile_mp: a default-geometry |
// |            instance and a DEPTH=24/NRD=3/NWR=1 instance for range checks.  |
// |            Expectations follow REGFILE_BYPASS_EN when it is defined.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // Instance A: defaults (32x32, NRD=2, NWR=2, ZERO_REG=1)
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [1:0]  a_wr_en;
  logic [9:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic        a_rsv_en;
  logic [4:0]  a_rsv_addr;
  logic        a_rsv_ok;

  // Instance B: DEPTH=24, NRD=3, NWR=1
  logic [14:0] b_rd_addr;
  logic [95:0] b_rd_data;
  logic [2:0]  b_rd_busy;
  logic [0:0]  b_wr_en;
  logic [4:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic        b_rsv_en;
  logic [4:0]  b_rsv_addr;
  logic        b_rsv_ok;

  regfile_mp dut_a (
    .clock    (clock),
    .reset    (reset),
    .rd_addr  (a_rd_addr),
    .rd_data  (a_rd_data),
    .rd_busy  (a_rd_busy),
    .wr_en    (a_wr_en),
    .wr_addr  (a_wr_addr),
    .wr_data  (a_wr_data),
    .rsv_en   (a_rsv_en),
    .rsv_addr (a_rsv_addr),
    .rsv_ok   (a_rsv_ok)
  );

  regfile_mp #(.DEPTH(24), .NRD(3), .NWR(1)) dut_b (
    .clock    (clock),
    .reset    (reset),
    .rd_addr  (b_rd_addr),
    .rd_data  (b_rd_data),
    .rd_busy  (b_rd_busy),
    .wr_en    (b_wr_en),
    .wr_addr  (b_wr_addr),
    .wr_data  (b_wr_data),
    .rsv_en   (b_rsv_en),
    .rsv_addr (b_rsv_addr),
    .rsv_ok   (b_rsv_ok)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    a_rd_addr = '0; a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0;
    a_rsv_en = 1'b0; a_rsv_addr = '0;
    b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
    b_rsv_en = 1'b0; b_rsv_addr = '0;

    // Reset state
    #3;
    chk("reset_rd_data", a_rd_data, 64'h0);
    chk("reset_rd_busy", a_rd_busy, 64'h0);
    chk("reset_rsv_ok",  a_rsv_ok,  64'h0);
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    tick();

    // Collision on register 5: port 1 wins
    a_wr_en = 2'b11;
    a_wr_addr = {5'd5, 5'd5};
    a_wr_data = {32'h5555FFFF, 32'hAAAA0000};
    a_rd_addr = {5'd0, 5'd5};
    #1;
    chk("collision_same_cycle", a_rd_data[31:0], BYP ? 64'h5555FFFF : 64'h0);
    tick();
    a_wr_en = 2'b00;
    #1;
    chk("collision_next_cycle", a_rd_data[31:0], 64'h5555FFFF);

    // Two independent writes
    a_wr_en = 2'b11;
    a_wr_addr = {5'd10, 5'd9};
    a_wr_data = {32'h22222222, 32'h11111111};
    tick();
    a_wr_en = 2'b00;
    a_rd_addr = {5'd10, 5'd9};
    #1;
    chk("dual_write_p0", a_rd_data[31:0],  64'h11111111);
    chk("dual_write_p1", a_rd_data[63:32], 64'h22222222);

    // Zero register
    a_wr_en = 2'b01;
    a_wr_addr = {5'd0, 5'd0};
    a_wr_data = {32'h0, 32'hDEADBEEF};
    a_rsv_en = 1'b1; a_rsv_addr = 5'd0;
    a_rd_addr = {5'd0, 5'd0};
    #1;
    chk("zero_rsv_ok", a_rsv_ok, 64'h1);
    chk("zero_read_same", a_rd_data[31:0], 64'h0);
    tick();
    a_wr_en = 2'b00; a_rsv_en = 1'b0;
    #1;
    chk("zero_read_after", a_rd_data[31:0], 64'h0);
    chk("zero_busy_after", a_rd_busy[0], 64'h0);

    // Scoreboard: reserve 7
    a_rd_addr = {5'd7, 5'd0};
    a_rsv_en = 1'b1; a_rsv_addr = 5'd7;
    #1;
    chk("rsv7_ok", a_rsv_ok, 64'h1);
    chk("rsv7_busy_before", a_rd_busy[1], 64'h0);
    tick();
    #1;
    chk("rsv7_busy_after", a_rd_busy[1], 64'h1);
    chk("rsv7_again_rejected", a_rsv_ok, 64'h0);
    tick();
    a_rsv_en = 1'b0;
    #1;
    chk("rsv7_busy_held", a_rd_busy[1], 64'h1);

    // Writeback clears busy
    a_wr_en = 2'b10;
    a_wr_addr = {5'd7, 5'd0};
    a_wr_data = {32'h00000077, 32'h0};
    tick();
    a_wr_en = 2'b00;
    #1;
    chk("wb7_clears_busy", a_rd_busy[1], 64'h0);
    chk("wb7_data", a_rd_data[63:32], 64'h77);

    // Write and reserve 7 together: set wins
    a_wr_en = 2'b01;
    a_wr_addr = {5'd0, 5'd7};
    a_wr_data = {32'h0, 32'h00000088};
    a_rsv_en = 1'b1; a_rsv_addr = 5'd7;
    #1;
    chk("setclr_rsv_ok", a_rsv_ok, 64'h1);
    chk("setclr_busy_same", a_rd_busy[1], BYP ? 64'h1 : 64'h0);
    chk("setclr_data_same", a_rd_data[63:32], BYP ? 64'h88 : 64'h77);
    tick();
    a_wr_en = 2'b00; a_rsv_en = 1'b0;
    #1;
    chk("setclr_busy_after", a_rd_busy[1], 64'h1);
    chk("setclr_data_after", a_rd_data[63:32], 64'h88);

    // Bypass on register 3
    a_rd_addr = {5'd0, 5'd3};
    a_wr_en = 2'b01;
    a_wr_addr = {5'd0, 5'd3};
    a_wr_data = {32'h0, 32'h12345678};
    #1;
    chk("bypass_same_cycle", a_rd_data[31:0], BYP ? 64'h12345678 : 64'h0);
    tick();
    a_wr_en = 2'b00;
    #1;
    chk("bypass_after_edge", a_rd_data[31:0], 64'h12345678);

    // Asynchronous reset mid-operation
    a_rd_addr = {5'd7, 5'd9};
    a_wr_en = 2'b01;
    a_wr_addr = {5'd0, 5'd9};
    a_wr_data = {32'h0, 32'h0000FFFF};
    a_rsv_en = 1'b1; a_rsv_addr = 5'd12;
    #1;
    chk("pre_reset_busy7", a_rd_busy[1], 64'h1);
    reset = 1'b0;
    #1;
    chk("async_reset_data", a_rd_data, 64'h0);
    chk("async_reset_busy", a_rd_busy, 64'h0);
    chk("async_reset_rsv_ok", a_rsv_ok, 64'h0);
    tick();
    chk("reset_held_data", a_rd_data, 64'h0);
    #2 reset = 1'b1;
    a_wr_en = 2'b00; a_rsv_en = 1'b0;
    #1;
    chk("no_write_in_reset", a_rd_data[31:0], 64'h0);
    a_rd_addr = {5'd0, 5'd12};
    #1;
    chk("no_rsv_in_reset", a_rd_busy[0], 64'h0);
    tick();

    // Instance B: out-of-range address 30 and boundary address 23
    b_wr_en = 1'b1; b_wr_addr = 5'd30; b_wr_data = 32'h0000CAFE;
    b_rsv_en = 1'b1; b_rsv_addr = 5'd30;
    b_rd_addr = {5'd30, 5'd0, 5'd0};
    #1;
    chk("oor_rsv_ok", b_rsv_ok, 64'h0);
    chk("oor_read_same", b_rd_data[95:64], 64'h0);
    tick();
    b_wr_addr = 5'd23; b_wr_data = 32'h00BEEF23;
    b_rsv_addr = 5'd23;
    #1;
    chk("oor_read_after", b_rd_data[95:64], 64'h0);
    chk("oor_busy_after", b_rd_busy[2], 64'h0);
    chk("top_rsv_ok", b_rsv_ok, 64'h1);
    tick();
    b_wr_en = 1'b0; b_rsv_en = 1'b0;
    b_rd_addr = {5'd30, 5'd23, 5'd23};
    #1;
    chk("top_data", b_rd_data[31:0], 64'h00BEEF23);
    chk("top_busy", b_rd_busy[1], 64'h1);
    chk("oor_data_final", b_rd_data[95:64], 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_regfile_mp
`default_nettype wire
